// File: rtl/ipv6_udp_pad_insert_pkg.sv
// rtl/ipv6_udp_pad_insert_pkg.sv - XGMII codes, pad FSM states and lane address helper
package ipv6_udp_pad_insert_pkg;

    localparam int          CNT_W      = 11;
    localparam logic [7:0]  XGMII_IDLE = 8'h07;
    localparam logic [7:0]  XGMII_TERM = 8'hFD;
    localparam logic [63:0] IDLE_BEAT  = {8{XGMII_IDLE}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_WAIT,
        ST_HOLD
    } pad_state_t;

    // 11-bit modulo octet address of a lane compared against a target address
    function automatic logic lane_hits(input logic [CNT_W-1:0] base, input int lane,
                                       input logic [CNT_W-1:0] addr);
        return (base + CNT_W'(lane)) == addr;
    endfunction

endpackage

// File: rtl/ipv6_udp_pad_insert_if.sv
// rtl/ipv6_udp_pad_insert_if.sv - TX stream and pad control bundle for the pad insert stage
interface ipv6_udp_pad_insert_if;
    import ipv6_udp_pad_insert_pkg::*;

    logic [63:0]      txd_i;
    logic [7:0]       txc_i;
    logic [CNT_W-1:0] eth_count_base_i;
    logic             ipv6_padchg_flag_i;
    logic [CNT_W-1:0] chkpad_addr_base_i;
    logic [15:0]      chksum_pad_i;
    logic [63:0]      txd_o;
    logic [7:0]       txc_o;
    logic [CNT_W-1:0] eth_count_base_o;
    logic             pad_patched_o;

    modport master (
        output txd_i, txc_i, eth_count_base_i, ipv6_padchg_flag_i, chkpad_addr_base_i, chksum_pad_i,
        input  txd_o, txc_o, eth_count_base_o, pad_patched_o
    );

    modport slave (
        input  txd_i, txc_i, eth_count_base_i, ipv6_padchg_flag_i, chkpad_addr_base_i, chksum_pad_i,
        output txd_o, txc_o, eth_count_base_o, pad_patched_o
    );

endinterface

// File: rtl/xgmii_delay_line.sv
// rtl/xgmii_delay_line.sv - enabled fixed-depth delay of an XGMII beat with its octet count
module xgmii_delay_line
    import ipv6_udp_pad_insert_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int CW    = 11
) (
    input  logic          tx_clk,
    input  logic          tx_rst_n,
    input  logic          clk_en_i,
    input  logic [63:0]   txd_i,
    input  logic [7:0]    txc_i,
    input  logic [CW-1:0] cnt_i,
    output logic [63:0]   txd_o,
    output logic [7:0]    txc_o,
    output logic [CW-1:0] cnt_o
);
    logic [63:0]   txd_q [DEPTH];
    logic [7:0]    txc_q [DEPTH];
    logic [CW-1:0] cnt_q [DEPTH];

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                txd_q[k] <= IDLE_BEAT;
                txc_q[k] <= '1;
                cnt_q[k] <= '0;
            end
        end else if (clk_en_i) begin
            txd_q[0] <= txd_i;
            txc_q[0] <= txc_i;
            cnt_q[0] <= cnt_i;
            for (int k = 1; k < DEPTH; k++) begin
                txd_q[k] <= txd_q[k-1];
                txc_q[k] <= txc_q[k-1];
                cnt_q[k] <= cnt_q[k-1];
            end
        end
    end

    assign txd_o = txd_q[DEPTH-1];
    assign txc_o = txc_q[DEPTH-1];
    assign cnt_o = cnt_q[DEPTH-1];

endmodule

// File: rtl/ipv6_udp_pad_insert.sv
// rtl/ipv6_udp_pad_insert.sv - delays the TX stream and overwrites the IPv6 UDP checksum pad octets
module ipv6_udp_pad_insert
    import ipv6_udp_pad_insert_pkg::*;
#(
    parameter int CHK_LAT = 2,
    parameter int DLY     = CHK_LAT + 1
) (
    input  logic tx_clk,
    input  logic tx_rst_n,
    input  logic tx_clk_en_i,
    ipv6_udp_pad_insert_if.slave bus
);
    localparam int LAT_W = $clog2(CHK_LAT + 1);

    pad_state_t       state;
    logic [CNT_W-1:0] pad_addr;
    logic [LAT_W-1:0] lat_cnt;
    logic [15:0]      hold;
    logic             hold_vld;

    logic [63:0]      dly_txd;
    logic [7:0]       dly_txc;
    logic [CNT_W-1:0] dly_cnt;
    logic             in_hit;
    logic             in_term;
    logic [63:0]      txd_patched;
    logic             lo_hit;

    xgmii_delay_line #(.DEPTH(DLY), .CW(CNT_W)) u_dly (
        .tx_clk   (tx_clk),
        .tx_rst_n (tx_rst_n),
        .clk_en_i (tx_clk_en_i),
        .txd_i    (bus.txd_i),
        .txc_i    (bus.txc_i),
        .cnt_i    (bus.eth_count_base_i),
        .txd_o    (dly_txd),
        .txc_o    (dly_txc),
        .cnt_o    (dly_cnt)
    );

    always_comb begin
        in_hit  = 1'b0;
        in_term = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!bus.txc_i[i] && lane_hits(bus.eth_count_base_i, i, pad_addr))
                in_hit = 1'b1;
            if (bus.txc_i[i] && bus.txd_i[8*i +: 8] == XGMII_TERM)
                in_term = 1'b1;
        end
    end

    // Patch is combinational on the last stage: hold only becomes valid in the cycle that beat emerges
    always_comb begin
        txd_patched = dly_txd;
        lo_hit      = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (hold_vld && !dly_txc[j] && lane_hits(dly_cnt, j, pad_addr))
                txd_patched[8*j +: 8] = hold[15:8];
            if (hold_vld && lane_hits(dly_cnt, j, pad_addr + CNT_W'(1))) begin
                txd_patched[8*j +: 8] = hold[7:0];
                lo_hit                = 1'b1;
            end
        end
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state    <= ST_IDLE;
            pad_addr <= '0;
            lat_cnt  <= '0;
            hold     <= '0;
            hold_vld <= 1'b0;
        end else if (tx_clk_en_i) begin
            case (state)
                ST_IDLE: begin
                    if (bus.ipv6_padchg_flag_i) begin
                        pad_addr <= bus.chkpad_addr_base_i;
                        state    <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (in_hit) begin
                        lat_cnt <= LAT_W'(CHK_LAT);
                        state   <= ST_WAIT;
                    end else if (in_term) begin
                        state <= ST_IDLE;
                    end else if (bus.ipv6_padchg_flag_i) begin
                        pad_addr <= bus.chkpad_addr_base_i;
                    end
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                    if (lat_cnt == LAT_W'(1)) begin
                        hold     <= bus.chksum_pad_i;
                        hold_vld <= 1'b1;
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (lo_hit) begin
                        hold_vld <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.txd_o            = txd_patched;
    assign bus.txc_o            = dly_txc;
    assign bus.eth_count_base_o = dly_cnt;
    assign bus.pad_patched_o    = lo_hit;

endmodule

// File: tb/tb_ipv6_udp_pad_insert.sv
// tb/tb_ipv6_udp_pad_insert.sv - random frame bench against a frame-level pad patch model
module tb_ipv6_udp_pad_insert;

    localparam int CHK_LAT = 2;
    localparam int DLY     = CHK_LAT + 1;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
        logic [10:0] n;
        logic        flag;
        logic [10:0] addr;
        logic [15:0] chk;
        logic [63:0] ed;
        logic        ep;
    } beat_t;

    logic tx_clk    = 1'b0;
    logic tx_rst_n  = 1'b0;
    logic tx_clk_en = 1'b0;

    ipv6_udp_pad_insert_if bus ();

    ipv6_udp_pad_insert #(.CHK_LAT(CHK_LAT), .DLY(DLY)) dut (
        .tx_clk      (tx_clk),
        .tx_rst_n    (tx_rst_n),
        .tx_clk_en_i (tx_clk_en),
        .bus         (bus)
    );

    always #5 tx_clk = ~tx_clk;

    int    total = 0;
    int    bad   = 0;
    int    pulses_seen = 0;
    int    pulses_exp  = 0;
    beat_t in_q[$];
    beat_t dly_q[$];
    beat_t last;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic beat_t idle_beat(input logic [10:0] a, input logic [15:0] cv);
        beat_t t;
        t.d    = {8{8'h07}};
        t.c    = 8'hFF;
        t.n    = '0;
        t.flag = 1'b0;
        t.addr = a;
        t.chk  = cv;
        t.ed   = t.d;
        t.ep   = 1'b0;
        return t;
    endfunction

    task automatic prefill();
        dly_q.delete();
        for (int i = 0; i < DLY - 1; i++) dly_q.push_back(idle_beat('0, '0));
        last = idle_beat('0, '0);
    endtask

    // Frame as an octet array: FB start, random data, FD terminate; pad octets a and a+1
    // are replaced by the compensation value when the frame carries the flag and holds both
    task automatic build_frame(input int len, input int a, input bit flag, input logic [15:0] cv);
        int    nb;
        int    p;
        int    k;
        bit    patched;
        beat_t t;
        logic [7:0] v;
        logic       ctl;
        nb      = len / 8 + 1;
        p       = a / 8;
        patched = flag && (a + 1 < len);
        for (int b = 0; b < nb; b++) begin
            t.ep = 1'b0;
            for (int l = 0; l < 8; l++) begin
                k = b * 8 + l;
                if (k == 0)        begin v = 8'hFB;         ctl = 1'b1; end
                else if (k < len)  begin v = 8'($urandom);  ctl = 1'b0; end
                else if (k == len) begin v = 8'hFD;         ctl = 1'b1; end
                else               begin v = 8'h07;         ctl = 1'b1; end
                t.d[8*l +: 8]  = v;
                t.c[l]         = ctl;
                t.ed[8*l +: 8] = v;
                if (patched && k == a) t.ed[8*l +: 8] = cv[15:8];
                if (patched && k == a + 1) begin
                    t.ed[8*l +: 8] = cv[7:0];
                    t.ep           = 1'b1;
                end
            end
            t.n    = 11'(b * 8);
            t.flag = flag && b >= 1 && b <= 3;
            t.addr = 11'(a);
            t.chk  = (b >= p + CHK_LAT) ? cv : 16'($urandom);
            in_q.push_back(t);
        end
        for (int g = 0; g < DLY + 1; g++) in_q.push_back(idle_beat(11'(a), cv));
    endtask

    task automatic drive_beat(input beat_t t);
        bus.txd_i              = t.d;
        bus.txc_i              = t.c;
        bus.eth_count_base_i   = t.n;
        bus.ipv6_padchg_flag_i = t.flag;
        bus.chkpad_addr_base_i = t.addr;
        bus.chksum_pad_i       = t.chk;
    endtask

    // mode 0: enable always on, 1: 1010 pattern, 2: random enable
    task automatic run(input int mode, input int limit);
        int    sent;
        int    cyc;
        bit    en;
        beat_t t;
        sent = 0;
        cyc  = 0;
        while (in_q.size() > 0 && (limit < 0 || sent < limit)) begin
            case (mode)
                0:       en = 1'b1;
                1:       en = (cyc % 2 == 0);
                default: en = ($urandom_range(0, 2) != 0);
            endcase
            cyc++;
            tx_clk_en = en;
            if (en) begin
                t = in_q.pop_front();
                drive_beat(t);
                dly_q.push_back(t);
                sent++;
            end else begin
                bus.txd_i              = {$urandom, $urandom};
                bus.txc_i              = 8'($urandom);
                bus.eth_count_base_i   = 11'($urandom);
                bus.ipv6_padchg_flag_i = 1'($urandom);
                bus.chkpad_addr_base_i = 11'($urandom);
                bus.chksum_pad_i       = 16'($urandom);
            end
            @(posedge tx_clk);
            #1;
            if (en) begin
                last = dly_q.pop_front();
                if (last.ep) pulses_exp++;
                if (bus.pad_patched_o) pulses_seen++;
            end
            chk_eq("txd", bus.txd_o, last.ed);
            chk_eq("txc", 64'(bus.txc_o), 64'(last.c));
            chk_eq("cnt", 64'(bus.eth_count_base_o), 64'(last.n));
            chk_eq("pulse", 64'(bus.pad_patched_o), 64'(last.ep));
        end
    endtask

    task automatic check_idle_out(input string tag);
        chk_eq({tag, "_txd"}, bus.txd_o, {8{8'h07}});
        chk_eq({tag, "_txc"}, 64'(bus.txc_o), 64'hFF);
        chk_eq({tag, "_cnt"}, 64'(bus.eth_count_base_o), 64'h0);
        chk_eq({tag, "_pulse"}, 64'(bus.pad_patched_o), 64'h0);
    endtask

    initial begin
        int len;
        int a;
        int sel;
        drive_beat(idle_beat('0, '0));
        repeat (3) @(posedge tx_clk);
        #1;
        check_idle_out("reset");
        tx_rst_n = 1'b1;
        prefill();

        build_frame(120, 'h5A, 1'b1, 16'hBEEF);
        run(0, -1);
        build_frame(120, 'h5F, 1'b1, 16'hBEEF);
        run(0, -1);
        build_frame(100, 'h40, 1'b0, 16'h1357);
        run(0, -1);
        build_frame(60, 'h5A, 1'b1, 16'h1234);
        run(0, -1);
        build_frame(120, 'h5A, 1'b1, 16'hBEEF);
        run(1, -1);

        // Reset while the FSM waits for the final compensation value
        build_frame(120, 'h5A, 1'b1, 16'hC0DE);
        run(0, 'h5A / 8 + 2);
        drive_beat(idle_beat('0, '0));
        tx_rst_n = 1'b0;
        #2;
        check_idle_out("midrst");
        @(posedge tx_clk);
        #1;
        check_idle_out("midrst_hold");
        tx_rst_n = 1'b1;
        in_q.delete();
        prefill();
        build_frame(120, 'h5A, 1'b1, 16'hBEEF);
        run(0, -1);

        for (int f = 0; f < 24; f++) begin
            len = $urandom_range(40, 180);
            sel = $urandom_range(0, 3);
            a   = (sel == 0) ? $urandom_range(len + 8, 400) : $urandom_range(16, len - 2);
            build_frame(len, a, ($urandom_range(0, 3) != 0), 16'($urandom));
            run($urandom_range(0, 2), -1);
        end

        chk_eq("pulse_total", 64'(pulses_seen), 64'(pulses_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
